// File: rtl/flow_light_pkg.sv
// Shared types and helpers for the running-light controller.
// Pure definitions: no latency, no flow control.
package flow_light_pkg;

  typedef logic [1:0] level_t;

  localparam logic [2:0] SPEED_CODE [0:3] = '{3'b000, 3'b001, 3'b011, 3'b111};

  // Step period in clock cycles; level 0 has no period (paused).
  function automatic int level_to_period(input level_t level, input int base_div);
    case (level)
      2'd1:    level_to_period = base_div;
      2'd2:    level_to_period = base_div / 2;
      2'd3:    level_to_period = base_div / 4;
      default: level_to_period = 0;
    endcase
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser plus rising-edge detector for one raw button.
// Pulse is high in the 2nd cycle after the raw edge is sampled; no backpressure.
module btn_sync_edge (
  input  logic I_CLK,
  input  logic Rst,
  input  logic btn,
  output logic pulse
);

  // sh[0], sh[1]: synchroniser; sh[2]: previous synchronised value
  logic [2:0] sh;

  always_ff @(posedge I_CLK or posedge Rst) begin
    if (Rst) sh <= '0;
    else     sh <= {sh[1:0], btn};
  end

  assign pulse = sh[1] & ~sh[2];

endmodule

// File: rtl/flow_light_ctrl.sv
// Running-light position, target and speed-code generator driven by three buttons.
// Button action lands 3 cycles after the raw edge is sampled; presses during lockout are dropped.
module flow_light_ctrl
  import flow_light_pkg::*;
#(
  parameter int BASE_DIV = 50000000,
  parameter int LOCKOUT  = 1000000
) (
  input  logic       I_CLK,
  input  logic       Rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_sel,
  output logic [2:0] flowspeed,
  output logic [1:0] count_light,
  output logic [1:0] count_light1,
  output logic [3:0] led,
  output logic       step,
  output logic       match
);

  localparam int TW = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
  localparam int LW = (LOCKOUT > 1) ? $clog2(LOCKOUT) : 1;

  logic          up_e, dn_e, sel_e;
  logic [LW-1:0] lock_cnt;
  logic          lock_free, acc_speed, acc_sel, accept;
  level_t        level, level_nxt;
  logic [TW-1:0] tick, tick_last;
  logic          wrap;
  logic [1:0]    cl_nxt;

  btn_sync_edge u_up   (.I_CLK(I_CLK), .Rst(Rst), .btn(btn_up),   .pulse(up_e));
  btn_sync_edge u_down (.I_CLK(I_CLK), .Rst(Rst), .btn(btn_down), .pulse(dn_e));
  btn_sync_edge u_sel  (.I_CLK(I_CLK), .Rst(Rst), .btn(btn_sel),  .pulse(sel_e));

  always_comb begin
    lock_free = (lock_cnt == '0);
    // up and down together cancel out and must not start a lockout
    acc_speed = lock_free & (up_e ^ dn_e);
    acc_sel   = lock_free & sel_e;
    accept    = acc_speed | acc_sel;

    level_nxt = level;
    if (acc_speed) begin
      if (up_e) begin
        if (level != 2'd3) level_nxt = level + 2'd1;
      end else if (level != 2'd0) begin
        level_nxt = level - 2'd1;
      end
    end

    tick_last = TW'(level_to_period(level, BASE_DIV) - 1);
    wrap      = (level != 2'd0) && (level_nxt == level) && (tick == tick_last);
    cl_nxt    = wrap ? count_light + 2'd1 : count_light;
  end

  always_ff @(posedge I_CLK or posedge Rst) begin
    if (Rst) begin
      lock_cnt <= '0;
    end else if (accept) begin
      lock_cnt <= LW'(LOCKOUT - 1);
    end else if (!lock_free) begin
      lock_cnt <= lock_cnt - LW'(1);
    end
  end

  always_ff @(posedge I_CLK or posedge Rst) begin
    if (Rst) begin
      level        <= 2'd0;
      flowspeed    <= 3'b000;
      tick         <= '0;
      step         <= 1'b0;
      count_light  <= 2'd0;
      count_light1 <= 2'd0;
      led          <= 4'b0001;
      match        <= 1'b0;
    end else begin
      level     <= level_nxt;
      flowspeed <= SPEED_CODE[level];
      // a speed change restarts the period so the first new step is a full period away
      if ((level_nxt != level) || (level == 2'd0) || wrap) tick <= '0;
      else                                                 tick <= tick + TW'(1);
      step        <= wrap;
      count_light <= cl_nxt;
      led         <= 4'b0001 << cl_nxt;
      if (acc_sel) count_light1 <= count_light1 + 2'd1;
      match <= (count_light == count_light1) && (flowspeed != 3'b000);
    end
  end

endmodule

// File: tb/tb_flow_light_ctrl.sv
// Directed bench for flow_light_ctrl with BASE_DIV = 8, LOCKOUT = 4.
// Inputs change and outputs are sampled 1 ns after the rising clock edge.
module tb_flow_light_ctrl;

  logic       I_CLK = 1'b0;
  logic       Rst = 1'b1;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_sel = 1'b0;
  logic [2:0] flowspeed;
  logic [1:0] count_light, count_light1;
  logic [3:0] led;
  logic       step, match;
  int         total = 0;
  int         bad = 0;

  always #5 I_CLK = ~I_CLK;

  flow_light_ctrl #(.BASE_DIV(8), .LOCKOUT(4)) dut (
    .I_CLK(I_CLK), .Rst(Rst), .btn_up(btn_up), .btn_down(btn_down), .btn_sel(btn_sel),
    .flowspeed(flowspeed), .count_light(count_light), .count_light1(count_light1),
    .led(led), .step(step), .match(match)
  );

  task automatic tick_n(input int n);
    repeat (n) @(posedge I_CLK);
    #1;
  endtask

  // Raw buttons high for exactly one clock; the next rising edge samples them.
  task automatic press(input logic u, input logic d, input logic s);
    btn_up = u; btn_down = d; btn_sel = s;
    tick_n(1);
    btn_up = 1'b0; btn_down = 1'b0; btn_sel = 1'b0;
  endtask

  task automatic do_reset();
    Rst = 1'b1; btn_up = 1'b0; btn_down = 1'b0; btn_sel = 1'b0;
    tick_n(2);
    Rst = 1'b0;
    tick_n(1);
  endtask

  task automatic test_reset();
    int steps, moved;
    Rst = 1'b1;
    tick_n(2);
    total++; if (flowspeed !== 3'b000) begin bad++; $display("FAIL reset_flowspeed got=%b exp=000", flowspeed); end
    total++; if (count_light !== 2'd0) begin bad++; $display("FAIL reset_count_light got=%0d exp=0", count_light); end
    total++; if (count_light1 !== 2'd0) begin bad++; $display("FAIL reset_count_light1 got=%0d exp=0", count_light1); end
    total++; if (led !== 4'b0001) begin bad++; $display("FAIL reset_led got=%b exp=0001", led); end
    total++; if (step !== 1'b0 || match !== 1'b0) begin bad++; $display("FAIL reset_step_match got=%b%b exp=00", step, match); end
    Rst = 1'b0;
    steps = 0; moved = 0;
    repeat (40) begin
      tick_n(1);
      if (step !== 1'b0) steps++;
      if (count_light !== 2'd0 || match !== 1'b0 || flowspeed !== 3'b000 || led !== 4'b0001) moved++;
    end
    total++; if (steps !== 0) begin bad++; $display("FAIL idle_step got=%0d pulses exp=0", steps); end
    total++; if (moved !== 0) begin bad++; $display("FAIL idle_outputs got=%0d changed cycles exp=0", moved); end
  endtask

  task automatic test_single_up();
    logic [1:0] exp_cl [3] = '{2'd2, 2'd3, 2'd0};
    logic [3:0] exp_led [3] = '{4'b0100, 4'b1000, 4'b0001};
    logic [1:0] prev;
    do_reset();
    press(1'b1, 1'b0, 1'b0);
    tick_n(2);
    total++; if (flowspeed !== 3'b000) begin bad++; $display("FAIL up_latency_early got=%b exp=000", flowspeed); end
    tick_n(1);
    total++; if (flowspeed !== 3'b001) begin bad++; $display("FAIL up_latency got=%b exp=001", flowspeed); end
    tick_n(6);
    total++; if (count_light !== 2'd0 || step !== 1'b0) begin bad++; $display("FAIL first_step_early got=cl%0d st%b exp=cl0 st0", count_light, step); end
    tick_n(1);
    total++; if (count_light !== 2'd1 || step !== 1'b1 || led !== 4'b0010) begin bad++; $display("FAIL first_step got=cl%0d st%b led%b exp=cl1 st1 led0010", count_light, step, led); end
    for (int i = 0; i < 3; i++) begin
      prev = count_light;
      tick_n(7);
      total++; if (step !== 1'b0 || count_light !== prev) begin bad++; $display("FAIL step_gap%0d got=cl%0d st%b exp=cl%0d st0", i, count_light, step, prev); end
      tick_n(1);
      total++; if (count_light !== exp_cl[i] || led !== exp_led[i] || step !== 1'b1) begin bad++; $display("FAIL step%0d got=cl%0d led%b st%b exp=cl%0d led%b st1", i, count_light, led, step, exp_cl[i], exp_led[i]); end
    end
  endtask

  task automatic test_saturate();
    logic [2:0] exp_up [5] = '{3'b001, 3'b011, 3'b111, 3'b111, 3'b111};
    logic [2:0] exp_dn [4] = '{3'b011, 3'b001, 3'b000, 3'b000};
    logic [1:0] cl0, cl_exp;
    int n, steps;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      press(1'b1, 1'b0, 1'b0);
      tick_n(3);
      total++; if (flowspeed !== exp_up[i]) begin bad++; $display("FAIL sat_up%0d got=%b exp=%b", i, flowspeed, exp_up[i]); end
      tick_n(6);
    end
    n = 0;
    while (step !== 1'b1 && n < 6) begin tick_n(1); n++; end
    total++; if (step !== 1'b1) begin bad++; $display("FAIL fast_step_seen got=%b exp=1 within 6 cycles", step); end
    cl0 = count_light;
    cl_exp = cl0 + 2'd1;
    tick_n(1);
    total++; if (step !== 1'b0 || count_light !== cl0) begin bad++; $display("FAIL fast_gap got=cl%0d st%b exp=cl%0d st0", count_light, step, cl0); end
    tick_n(1);
    total++; if (step !== 1'b1 || count_light !== cl_exp) begin bad++; $display("FAIL fast_period got=cl%0d st%b exp=cl%0d st1", count_light, step, cl_exp); end
    for (int i = 0; i < 4; i++) begin
      press(1'b0, 1'b1, 1'b0);
      tick_n(3);
      total++; if (flowspeed !== exp_dn[i]) begin bad++; $display("FAIL sat_down%0d got=%b exp=%b", i, flowspeed, exp_dn[i]); end
      tick_n(6);
    end
    cl0 = count_light;
    steps = 0;
    repeat (20) begin
      tick_n(1);
      if (step !== 1'b0 || count_light !== cl0) steps++;
    end
    total++; if (steps !== 0) begin bad++; $display("FAIL paused_frozen got=%0d moving cycles exp=0", steps); end
  endtask

  task automatic test_up_down_same();
    do_reset();
    press(1'b1, 1'b0, 1'b0);
    tick_n(9);
    press(1'b1, 1'b1, 1'b0);
    tick_n(1);
    press(1'b1, 1'b0, 1'b0);
    tick_n(1);
    total++; if (flowspeed !== 3'b001) begin bad++; $display("FAIL updown_ignored got=%b exp=001", flowspeed); end
    tick_n(2);
    total++; if (flowspeed !== 3'b011) begin bad++; $display("FAIL updown_no_lockout got=%b exp=011", flowspeed); end
  endtask

  task automatic test_lockout();
    do_reset();
    press(1'b1, 1'b0, 1'b0);
    tick_n(1);
    press(1'b1, 1'b0, 1'b0);
    tick_n(3);
    total++; if (flowspeed !== 3'b001) begin bad++; $display("FAIL lockout_drop got=%b exp=001", flowspeed); end
    press(1'b1, 1'b0, 1'b0);
    tick_n(2);
    total++; if (flowspeed !== 3'b001) begin bad++; $display("FAIL lockout_third_early got=%b exp=001", flowspeed); end
    tick_n(1);
    total++; if (flowspeed !== 3'b011) begin bad++; $display("FAIL lockout_release got=%b exp=011", flowspeed); end
  endtask

  task automatic test_target_match();
    int n;
    do_reset();
    press(1'b0, 1'b0, 1'b1);
    tick_n(9);
    total++; if (count_light1 !== 2'd1 || flowspeed !== 3'b000) begin bad++; $display("FAIL sel_paused got=t%0d fs%b exp=t1 fs000", count_light1, flowspeed); end
    press(1'b1, 1'b0, 1'b1);
    tick_n(9);
    total++; if (count_light1 !== 2'd2 || flowspeed !== 3'b001) begin bad++; $display("FAIL sel_with_up got=t%0d fs%b exp=t2 fs001", count_light1, flowspeed); end
    n = 0;
    while (match !== 1'b0 && n < 20) begin tick_n(1); n++; end
    n = 0;
    while (match !== 1'b1 && n < 40) begin tick_n(1); n++; end
    total++; if (match !== 1'b1 || count_light !== 2'd2) begin bad++; $display("FAIL match_rise got=m%b cl%0d exp=m1 cl2", match, count_light); end
    n = 0;
    while (match === 1'b1 && n < 20) begin tick_n(1); n++; end
    total++; if (n !== 8) begin bad++; $display("FAIL match_width got=%0d exp=8", n); end
    tick_n(2);
    #3 Rst = 1'b1;
    #1;
    total++; if (flowspeed !== 3'b000 || count_light !== 2'd0 || count_light1 !== 2'd0) begin bad++; $display("FAIL async_reset_a got=fs%b cl%0d t%0d exp=fs000 cl0 t0", flowspeed, count_light, count_light1); end
    total++; if (led !== 4'b0001 || step !== 1'b0 || match !== 1'b0) begin bad++; $display("FAIL async_reset_b got=led%b st%b m%b exp=led0001 st0 m0", led, step, match); end
    tick_n(1);
    Rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_up();
    test_saturate();
    test_up_down_same();
    test_lockout();
    test_target_match();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
